// File: rtl/rvcpu_pkg.sv
// ============================================================================
//  Module      : rvcpu_pkg
//  Description : Shared types and constants for the riscv_core bench memory.
//  Revision    : 1.0 - initial wait-state memory support
// ============================================================================
`default_nettype none

package rvcpu_pkg;

    localparam int DATA_WIDTH = 32;

    typedef logic [DATA_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        WSM_IDLE = 2'd0,
        WSM_WAIT = 2'd1,
        WSM_RESP = 2'd2
    } wsm_state_e;

    // Byte offsets of the MMIO registers from the window base
    localparam int HALT_OFF  = 0;
    localparam int CYCLE_OFF = 4;

endpackage

`default_nettype wire

// File: rtl/sp_ram_bytemask.sv
// ============================================================================
//  Module      : sp_ram_bytemask
//  Description : Single-port word array, per-byte write enable, async read.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sp_ram_bytemask #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic [WIDTH/8-1:0] we_mask,
    input  logic [AW-1:0]      addr,
    input  logic [WIDTH-1:0]   w_data,
    output logic [WIDTH-1:0]   r_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < WIDTH/8; b++) begin
            if (we_mask[b]) begin
                r_mem[addr][b*8 +: 8] <= w_data[b*8 +: 8];
            end
        end
    end

    assign r_data = r_mem[addr];

endmodule

`default_nettype wire

// File: rtl/wait_state_mem.sv
// ============================================================================
//  Module      : wait_state_mem
//  Description : Bench data memory with wait states, error reporting, MMIO
//                halt register and a cycle watchdog.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_state_mem
    import rvcpu_pkg::*;
#(
    parameter int               WIDTH          = DATA_WIDTH,
    parameter int               DEPTH          = 1024,
    parameter int               LATENCY        = 2,
    parameter logic [WIDTH-1:0] MMIO_BASE      = WIDTH'(32'hFFFF_0000),
    parameter int               TIMEOUT_CYCLES = 200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [WIDTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]   req_w_data,
    input  logic [WIDTH/8-1:0] req_w_mask,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_err,
    output logic               halt,
    output logic [WIDTH-1:0]   halt_code,
    output logic               timeout
);

    localparam int               c_nb          = WIDTH / 8;
    localparam int               c_aw          = $clog2(DEPTH);
    localparam logic [3:0]       c_wait_init   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
    localparam logic [WIDTH-1:0] c_ram_bytes   = WIDTH'(DEPTH * 4);
    localparam logic [WIDTH-1:0] c_mmio_span   = WIDTH'(4096);
    localparam logic [WIDTH-1:0] c_timeout_val = WIDTH'(TIMEOUT_CYCLES - 1);

    wsm_state_e       r_state, w_state_next;
    logic [3:0]       r_cnt, w_cnt_next;
    logic             r_we;
    logic [WIDTH-1:0] r_addr, r_wdata;
    logic [c_nb-1:0]  r_mask;
    logic             r_rsp_valid, r_rsp_err;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_halt, r_timeout;
    logic [WIDTH-1:0] r_halt_code, r_cycles, w_cycles_next;
    logic             w_accept, w_misaligned, w_in_mmio, w_in_ram;
    logic             w_halt_set, w_rsp_err;
    logic [WIDTH-1:0] w_off, w_rsp_data, w_ram_rdata;
    logic [c_nb-1:0]  w_ram_we;

    assign req_ready = (r_state == WSM_IDLE);
    assign w_accept  = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= WSM_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            WSM_IDLE: begin
                if (req_valid) begin
                    w_cnt_next   = c_wait_init;
                    w_state_next = (LATENCY > 0) ? WSM_WAIT : WSM_RESP;
                end
            end
            WSM_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = WSM_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            WSM_RESP: w_state_next = WSM_IDLE;
            default:  w_state_next = WSM_IDLE;
        endcase
    end

    // Decode of the captured request; only has effect during RESP
    assign w_off        = r_addr - MMIO_BASE;
    assign w_misaligned = |r_addr[1:0];
    assign w_in_mmio    = (r_addr >= MMIO_BASE) && (w_off < c_mmio_span);
    assign w_in_ram     = (r_addr < c_ram_bytes);

    always_comb begin
        w_rsp_data = '0;
        w_rsp_err  = 1'b0;
        w_ram_we   = '0;
        w_halt_set = 1'b0;
        if (r_state == WSM_RESP) begin
            if (w_misaligned) begin
                w_rsp_err = 1'b1;
            end else if (w_in_mmio) begin
                if (w_off == WIDTH'(HALT_OFF)) begin
                    if (r_we) w_halt_set = 1'b1;
                    else      w_rsp_data = r_halt_code;
                end else if (w_off == WIDTH'(CYCLE_OFF)) begin
                    if (!r_we) w_rsp_data = r_cycles;
                end else begin
                    w_rsp_err = 1'b1;
                end
            end else if (w_in_ram) begin
                if (r_we) w_ram_we   = r_mask;
                else      w_rsp_data = w_ram_rdata;
            end else begin
                w_rsp_err = 1'b1;
            end
        end
    end

    assign w_cycles_next = (&r_cycles) ? r_cycles : r_cycles + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_halt      <= 1'b0;
            r_halt_code <= '0;
            r_cycles    <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_w_data;
                r_mask  <= req_w_mask;
            end
            r_rsp_valid <= (r_state == WSM_RESP);
            if (r_state == WSM_RESP) begin
                r_rsp_data <= w_rsp_data;
                r_rsp_err  <= w_rsp_err;
            end
            if (w_halt_set) begin
                r_halt      <= 1'b1;
                r_halt_code <= r_wdata;
            end
            r_cycles <= w_cycles_next;
            // A halt landing on the expiry edge suppresses the timeout
            if (!r_halt && !w_halt_set && (r_cycles != c_timeout_val) &&
                (w_cycles_next == c_timeout_val)) begin
                r_timeout <= 1'b1;
            end
        end
    end

    sp_ram_bytemask #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (c_aw)
    ) u_ram (
        .clk     (clk),
        .we_mask (w_ram_we),
        .addr    (r_addr[c_aw+1:2]),
        .w_data  (r_wdata),
        .r_data  (w_ram_rdata)
    );

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_err   = r_rsp_err;
    assign halt      = r_halt;
    assign halt_code = r_halt_code;
    assign timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_wait_state_mem.sv
// ============================================================================
//  Module      : tb_wait_state_mem
//  Description : Scoreboard bench for wait_state_mem (Latency 2 and 0 builds).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wait_state_mem;

    localparam int          LAT = 2;
    localparam logic [31:0] MB  = 32'hFFFF_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [31:0] req_addr = '0, req_w_data = '0;
    logic [3:0]  req_w_mask = '0;
    logic        req_ready, rsp_valid, rsp_err, halt, timeout;
    logic [31:0] rsp_data, halt_code;

    logic        req_valid_0 = 1'b0, req_we_0 = 1'b0;
    logic [31:0] req_addr_0 = '0, req_w_data_0 = '0;
    logic [3:0]  req_w_mask_0 = '0;
    logic        req_ready_0, rsp_valid_0, rsp_err_0, halt_0, timeout_0;
    logic [31:0] rsp_data_0, halt_code_0;

    wait_state_mem #(.LATENCY(LAT), .MMIO_BASE(MB), .TIMEOUT_CYCLES(200)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_w_data(req_w_data),
        .req_w_mask(req_w_mask), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .halt(halt), .halt_code(halt_code), .timeout(timeout)
    );

    wait_state_mem #(.LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid_0), .req_ready(req_ready_0),
        .req_we(req_we_0), .req_addr(req_addr_0), .req_w_data(req_w_data_0),
        .req_w_mask(req_w_mask_0), .rsp_valid(rsp_valid_0), .rsp_data(rsp_data_0),
        .rsp_err(rsp_err_0), .halt(halt_0), .halt_code(halt_code_0), .timeout(timeout_0)
    );

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;
    int rel  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          at;
        bit          chk_halt;
        logic [31:0] hcode;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        nvec++;
        if (act !== want) begin
            nmis++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    // Monitor: every response strobe must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                nvec++;
                nmis++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 data=%h, want no response", rsp_data);
            end else begin
                e = sb.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                check("rsp_cycle", cyc, e.at);
                if (e.chk_halt) begin
                    check("halt_on_rsp", {31'd0, halt}, 32'd1);
                    check("halt_code_on_rsp", halt_code, e.hcode);
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic [31:0] want_data,
                         input logic want_err, input bit push, input bit chk_halt,
                         input logic [31:0] want_hcode, input bit cyc_read, input bit chk_ready);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_w_data = data; req_w_mask = mask;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            nvec++;
            nmis++;
            $display("FAIL accept_timeout: got req_ready=%b, want 1", req_ready);
        end
        e.at       = cyc + LAT + 2;
        e.data     = cyc_read ? 32'(e.at - 1 - rel) : want_data;
        e.err      = want_err;
        e.chk_halt = chk_halt;
        e.hcode    = want_hcode;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_w_data = '0; req_w_mask = '0;
        if (chk_ready) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                check("ready_after_accept", {31'd0, req_ready}, (i < 3) ? 32'd0 : 32'd1);
            end
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] want, input logic err);
        issue(1'b0, addr, 32'd0, 4'h0, want, err, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                      input logic err);
        issue(1'b1, addr, data, mask, 32'd0, err, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            nvec++;
            nmis++;
            $display("FAIL drain_timeout: got %0d pending, want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_rsp_data"}, rsp_data, 32'd0);
        check({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        check({tag, "_halt"}, {31'd0, halt}, 32'd0);
        check({tag, "_halt_code"}, halt_code, 32'd0);
        check({tag, "_timeout"}, {31'd0, timeout}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared(tag);
        rst = 1'b1;
        rel = cyc;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL bench_watchdog: got no finish, want finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int hits;
        do_reset("reset");

        // Full-word write then read, with ready profile checked
        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
        drain();
        rd(32'h10, 32'hDEAD_BEEF, 1'b0);
        drain();
        wr(32'h10, 32'h0000_00AA, 4'b0001, 1'b0);
        rd(32'h10, 32'hDEAD_BEAA, 1'b0);
        wr(32'h10, 32'hFFFF_FFFF, 4'b0000, 1'b0);
        rd(32'h10, 32'hDEAD_BEAA, 1'b0);

        // Error paths must leave RAM untouched
        wr(32'h0, 32'h1111_1111, 4'hF, 1'b0);
        rd(32'h12, 32'd0, 1'b1);
        rd(32'h1000, 32'd0, 1'b1);
        wr(32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b1);
        wr(32'h11, 32'h0, 4'hF, 1'b1);
        rd(32'h0, 32'h1111_1111, 1'b0);
        rd(32'h10, 32'hDEAD_BEAA, 1'b0);
        wr(32'h20, 32'h1234_5678, 4'hF, 1'b0);
        rd(32'h20, 32'h1234_5678, 1'b0);
        drain();

        // Zero-latency build: response one cycle after accept
        @(negedge clk);
        req_valid_0 = 1'b1; req_we_0 = 1'b1; req_addr_0 = 32'h4;
        req_w_data_0 = 32'hCAFE_F00D; req_w_mask_0 = 4'hF;
        @(posedge clk);
        #1;
        req_valid_0 = 1'b0; req_we_0 = 1'b0;
        @(negedge clk);
        check("lat0_wr_early", {31'd0, rsp_valid_0}, 32'd0);
        @(negedge clk);
        check("lat0_wr_valid", {31'd0, rsp_valid_0}, 32'd1);
        check("lat0_wr_err", {31'd0, rsp_err_0}, 32'd0);
        req_valid_0 = 1'b1;
        @(posedge clk);
        #1;
        req_valid_0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("lat0_rd_valid", {31'd0, rsp_valid_0}, 32'd1);
        check("lat0_rd_data", rsp_data_0, 32'hCAFE_F00D);

        // Reset during WAIT of a write: dropped, no response
        issue(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        do_reset("midreset");
        hits = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) hits++;
        end
        check("midreset_no_rsp", 32'(hits), 32'd0);
        check_cleared("post_release");
        rd(32'h20, 32'h1234_5678, 1'b0);
        drain();

        // Watchdog with no halt
        do_reset("wd_reset");
        wait_until(rel + 198);
        check("timeout_before", {31'd0, timeout}, 32'd0);
        @(negedge clk);
        check("timeout_at_199", {31'd0, timeout}, 32'd1);
        repeat (20) @(negedge clk);
        check("timeout_sticky", {31'd0, timeout}, 32'd1);

        // Halt landing on the expiry edge wins
        do_reset("tie_reset");
        wait_until(rel + 194);
        issue(1'b1, MB, 32'h7, 4'h0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h7, 1'b0, 1'b0);
        drain();
        check("tie_timeout", {31'd0, timeout}, 32'd0);
        repeat (20) @(negedge clk);
        check("tie_timeout_later", {31'd0, timeout}, 32'd0);
        check("tie_halt", {31'd0, halt}, 32'd1);

        // Early halt, MMIO reads, and no timeout afterwards
        do_reset("halt_reset");
        wait_until(rel + 49);
        issue(1'b1, MB, 32'h1, 4'h0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h1, 1'b0, 1'b0);
        rd(MB, 32'h1, 1'b0);
        issue(1'b0, MB + 32'd4, 32'd0, 4'h0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
        wr(MB + 32'd4, 32'hFFFF_FFFF, 4'hF, 1'b0);
        rd(MB + 32'd8, 32'd0, 1'b1);
        wr(MB, 32'h55, 4'hF, 1'b0);
        rd(MB, 32'h55, 1'b0);
        drain();
        hits = 0;
        while (cyc <= rel + 300) begin
            @(negedge clk);
            if (timeout !== 1'b0) hits++;
        end
        check("halt_no_timeout", 32'(hits), 32'd0);
        check("halt_sticky", {31'd0, halt}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wait_state_mem.md
Name: wait_state_mem

Overview:
- Parametrised simulation data memory for the riscv_core bench.
- Successor to the fixed zero-latency ram used in the bench top.
- Adds:
  - a valid/ready request channel and a registered response channel
  - configurable wait states
  - address range and alignment error reporting
  - an MMIO halt register and a cycle watchdog
- Together these let the bench end a test from software, or on a timeout, instead of relying on a fixed simulation delay.

Parameters:
- Width, rvcpu::Width (32): data and address width.
- Depth, 1024: number of Width-bit words. Must be a power of two, at least 2.
- Latency, 2: wait cycles between acceptance and response, 0..15.
- MmioBase, 32'hFFFF_0000: base address of the MMIO window.
- TimeoutCycles, 200: watchdog limit in clk cycles after reset release.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, asynchronous, active-low.
- req_valid, in, 1: request present.
- req_ready, out, 1: block can accept a request.
- req_we, in, 1: 1 = write, 0 = read.
- req_addr, in, Width: byte address.
- req_w_data, in, Width: write data.
- req_w_mask, in, Width/8: byte write enables.
- rsp_valid, out, 1: one-cycle response strobe.
- rsp_data, out, Width: read data; 0 for writes and errors.
- rsp_err, out, 1: request faulted. Qualified by rsp_valid.
- halt, out, 1: sticky; software wrote the halt register.
- halt_code, out, Width: value written to the halt register.
- timeout, out, 1: sticky; watchdog expired before halt.

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE.
  - req_ready=1; rsp_valid=0, rsp_data=0, rsp_err=0.
  - halt=0, halt_code=0, timeout=0; cycle counter=0.
  - Memory array contents are not reset.
  - A request in flight when reset asserts is dropped: no write, no response.
- FSM states and transitions:
  - IDLE: req_ready=1. On req_valid&&req_ready, capture we/addr/data/mask. Go to WAIT if Latency>0, else RESP. Wait counter loads Latency-1.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: req_ready=0. Perform the access, drive rsp_valid=1 for exactly one cycle with rsp_data/rsp_err, then return to IDLE.
- Timing:
  - The response arrives Latency+1 cycles after the acceptance edge.
  - Back-to-back throughput is one request per Latency+2 cycles.
  - rsp_data and rsp_err hold their values until the next response. rsp_valid is the only strobe.
- Address decode, evaluated in RESP:
  - Misaligned (addr[1:0]!=0): rsp_err=1, no side effects.
  - MMIO, addr==MmioBase: a write sets halt=1 and halt_code=w_data; req_w_mask is ignored. A read returns halt_code.
  - MMIO, addr==MmioBase+4: a read returns the cycle counter (zero-extended); a write is ignored, rsp_err=0.
  - Other addresses in [MmioBase, MmioBase+0xFFF]: rsp_err=1.
  - RAM, addr < Depth*4: word index is addr[$clog2(Depth)+1:2]. A write updates only the bytes with their mask bit set; mask=0 is a legal no-op. A read returns the full word.
  - Anything else: rsp_err=1, no write.
- Halt register:
  - halt is sticky until reset.
  - A second halt write updates halt_code.
- Cycle counter and watchdog:
  - The counter is Width wide, increments every cycle after reset release, and saturates at all-ones.
  - timeout sets when counter==TimeoutCycles-1 and halt==0. It is sticky until reset.
  - If halt and the expiry cycle coincide, halt wins and timeout stays 0.
  - Once halt=1, timeout never sets.
- The request channel is not affected by halt or timeout; the bench decides what to do with them.
- req_* inputs are ignored whenever req_ready=0.

Decomposition:
- rvcpu package gets:
  - typedef wsm_state_e (IDLE, WAIT, RESP)
  - localparams for MMIO offsets HaltOff=0 and CycleOff=4
- Reuse rvcpu::addr_t / data_t.
- One sub-module: sp_ram_bytemask.
  - Single-port synchronous array, Depth x Width, no reset.
  - Per-byte write enable; combinational read of the addressed word.
  - wait_state_mem instantiates it and muxes the MMIO and error paths around it.

Test Plan:
- Latency=2. Write 0xDEADBEEF, mask 4'hF, to addr 0x10; then read 0x10. The write rsp_valid comes 3 cycles after acceptance with rsp_err=0; the read returns 0xDEADBEEF. req_ready is 0 for 3 cycles after each accept.
- After the above, write 0x000000AA with mask 4'b0001 to 0x10; the next read returns 0xDEADBEAA. Latency=0 build: response comes 1 cycle after accept.
- Read 0x12 (misaligned) and read Depth*4 (out of range). Both give rsp_err=1 and rsp_data=0, and RAM is unchanged.
- Write 0x1 to MmioBase at cycle 50. halt=1 and halt_code=1 on the response cycle; timeout stays 0 through cycle 300. Reading MmioBase+4 returns a value strictly greater than 50.
- No halt write, TimeoutCycles=200: timeout rises on the cycle the counter equals 199 and stays high. Halt written on exactly that cycle: timeout=0, halt=1.
- Assert rst low during WAIT of a write to 0x20. No response follows. After release, req_ready=1 and all outputs are 0; reading 0x20 returns its prior contents.
